buzzer_arbiter: RTL and testbench
=================================

# buzzer_arbiter

Shares the single LCD-shield buzzer line (`lcd_buzzer`, ARDUINO_IO[12]) between the four game-event sound requesters: player death, gold eaten, diamond eaten and shot fired. The block latches one-cycle event pulses, grants the buzzer to the highest-priority pending event, and generates a square-wave tone for a per-event number of frames. It runs on `clk_25` beside the game objects and is paced by the `startOfFrame` strobe.

## Interface
Parameters:
- `HP_DIED`, 12500: tone half-period in clocks for the death sound (1 kHz at 25 MHz).
- `HP_GOLD`, 6250: gold tone half-period (2 kHz).
- `HP_DIMOND`, 4167: diamond tone half-period (~3 kHz).
- `HP_SHOT`, 25000: shot tone half-period (500 Hz).
- `DUR_DIED`, 30: death sound length in frames.
- `DUR_GOLD`, 8: gold sound length in frames.
- `DUR_DIMOND`, 4: diamond sound length in frames.
- `DUR_SHOT`, 3: shot sound length in frames.
- `GAP_FRAMES`, 2: enforced silence between consecutive sounds, in frames.

Ports:
- `clk`, in, 1: system clock (`clk_25`).
- `reset`, in, 1: asynchronous, active-high reset.
- `startOfFrame`, in, 1: one-cycle frame strobe.
- `mute`, in, 1: level; silences output and flushes all requests.
- `req_died`, in, 1: pulse, priority 0 (highest).
- `req_gold`, in, 1: pulse, priority 1.
- `req_dimond`, in, 1: pulse, priority 2.
- `req_shot`, in, 1: pulse, priority 3 (lowest).
- `buzzer`, out, 1: registered square-wave output.
- `busy`, out, 1: high in PLAY or GAP.
- `active_src`, out, 2: index of the sound now playing, or the last one played.

## Operation
- `pending[3:0]` holds one bit per source. A request sets its bit on the next edge. Multiple requests for the same source collapse into one bit.
- States:
  - **IDLE**: if `pending` is nonzero, grant the lowest set index on the next edge. On grant: go to PLAY; load `active_src`; clear that pending bit; `tone_cnt`=0; `buzzer`=0; `frame_cnt`=DUR of that source.
  - **PLAY**: `tone_cnt` counts up. When it reaches HP−1, `buzzer` toggles and `tone_cnt` returns to 0. On each `startOfFrame`, `frame_cnt` decrements. When it decrements from 1, go to GAP on the same edge with `buzzer`=0 and `gap_cnt`=GAP_FRAMES.
  - **GAP**: `buzzer` is held at 0. `gap_cnt` decrements on each `startOfFrame`. When it decrements from 1, go to IDLE.
- Preemption: in PLAY, a pending source with strictly higher priority than `active_src` is granted on the next edge with the grant loading above, skipping GAP. The preempted sound is dropped and does not resume. Pending sources of equal or lower priority wait.
- Retrigger: a request for `active_src` while in PLAY reloads `frame_cnt` to its DUR without resetting the tone phase, and does not set `pending`.
- `mute` high: on the next edge go to IDLE, clear `pending`, and set `buzzer`=0. While `mute` is high, requests are ignored.
- Simultaneous request and grant of the same bit in IDLE: the grant wins and the bit ends up cleared.
- `startOfFrame` coinciding with a grant edge does not decrement the newly loaded `frame_cnt`.

## Timing
- Reset values: `buzzer`=0, `busy`=0, `active_src`=0, state IDLE, `pending`=0, all counters 0.
- Latency from a request pulse at edge t (IDLE, unmuted): `pending` set after t; PLAY and `busy` high after t+1; first `buzzer` rise after t+1+HP.
- `busy` is registered and equals (state != IDLE).
- Counter widths: `tone_cnt` 15 bits, `frame_cnt` 6 bits, `gap_cnt` 2 bits. Parameters are checked at elaboration: HP ≤ 32767, DUR in 1..63, GAP_FRAMES in 1..3.
- Asserting `reset` mid-sound forces the reset values immediately.

## Structure
- A shared package `sound_pkg` holds:
  - the state enum `snd_state_t` {IDLE, PLAY, GAP};
  - source index constants SND_DIED=0, SND_GOLD=1, SND_DIMOND=2, SND_SHOT=3;
  - default HP and DUR constants.
- One natural sub-module, `tone_gen`: a half-period counter plus toggle flop, with inputs `clk`, `reset`, `clear`, `half_period` and output `wave`.
- The arbiter and frame-timer FSM stay in `buzzer_arbiter`.

## Test plan
- `req_shot` pulse at cycle 10, frame strobe every 1000 clocks, HP_SHOT overridden to 100:
  - `busy` high at cycle 12;
  - `buzzer` toggles every 100 clocks;
  - sound lasts 3 frames, then 2 frames of silence, then `busy`=0.
- `req_dimond` and `req_gold` in the same cycle: gold plays first (`active_src`=1), then GAP, then diamond (`active_src`=2).
- During a shot in PLAY, pulse `req_died`: the next edge shows `active_src`=0, `tone_cnt` restarted, no GAP, and the shot is never replayed.
- During gold in PLAY with `frame_cnt`=2, pulse `req_gold`: `frame_cnt` reloads to 8, the tone phase is continuous, and `pending[1]` stays 0.
- During PLAY with `pending`=4'b1000, raise `mute` for 5 cycles:
  - next edge shows IDLE, `pending`=0, `buzzer`=0;
  - requests during mute are ignored;
  - after `mute` falls, the output stays silent.
- Assert `reset` asynchronously mid-PLAY while `buzzer`=1: all outputs go to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared definitions for the buzzer arbiter: FSM states, source indices,
// default tone/duration constants and counter widths.
package sound_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } snd_state_t;

  // Source index doubles as priority: lower index wins.
  localparam logic [1:0] SND_DIED   = 2'd0;
  localparam logic [1:0] SND_GOLD   = 2'd1;
  localparam logic [1:0] SND_DIMOND = 2'd2;
  localparam logic [1:0] SND_SHOT   = 2'd3;

  // Defaults assume a 25 MHz clock.
  localparam int HP_DIED_DEF    = 12500;
  localparam int HP_GOLD_DEF    = 6250;
  localparam int HP_DIMOND_DEF  = 4167;
  localparam int HP_SHOT_DEF    = 25000;
  localparam int DUR_DIED_DEF   = 30;
  localparam int DUR_GOLD_DEF   = 8;
  localparam int DUR_DIMOND_DEF = 4;
  localparam int DUR_SHOT_DEF   = 3;
  localparam int GAP_FRAMES_DEF = 2;

  localparam int TONE_W  = 15;
  localparam int FRAME_W = 6;
  localparam int GAP_W   = 2;

  // Index of the lowest set bit (highest-priority pending source).
  // Returns 0 for an all-zero vector; callers qualify with a nonzero test.
  function automatic logic [1:0] lowest_set(input logic [3:0] vec);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 2'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: counts clocks up to half_period-1, then toggles
// the output. 'clear' restarts the phase with the output low.
module tone_gen
  import sound_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [TONE_W-1:0] half_period,
  output logic              wave
);

  logic [TONE_W-1:0] cnt_r;
  logic              wave_r;

  // Half-period counter with toggle flop; >= keeps it safe if the period shrinks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r  <= {TONE_W{1'b0}};
      wave_r <= 1'b0;
    end else if (clear) begin
      cnt_r  <= {TONE_W{1'b0}};
      wave_r <= 1'b0;
    end else if (cnt_r >= (half_period - 15'd1)) begin
      cnt_r  <= {TONE_W{1'b0}};
      wave_r <= ~wave_r;
    end else begin
      cnt_r  <= cnt_r + 15'd1;
      wave_r <= wave_r;
    end
  end

  assign wave = wave_r;

endmodule

// File: rtl/buzzer_arbiter.sv
// Buzzer arbiter: latches one-cycle sound requests, grants the buzzer to the
// highest-priority pending source, plays a tone for a number of frames and
// then enforces a silent gap before the next sound.
module buzzer_arbiter
  import sound_pkg::*;
#(
  parameter int HP_DIED    = HP_DIED_DEF,
  parameter int HP_GOLD    = HP_GOLD_DEF,
  parameter int HP_DIMOND  = HP_DIMOND_DEF,
  parameter int HP_SHOT    = HP_SHOT_DEF,
  parameter int DUR_DIED   = DUR_DIED_DEF,
  parameter int DUR_GOLD   = DUR_GOLD_DEF,
  parameter int DUR_DIMOND = DUR_DIMOND_DEF,
  parameter int DUR_SHOT   = DUR_SHOT_DEF,
  parameter int GAP_FRAMES = GAP_FRAMES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       mute,
  input  logic       req_died,
  input  logic       req_gold,
  input  logic       req_dimond,
  input  logic       req_shot,
  output logic       buzzer,
  output logic       busy,
  output logic [1:0] active_src
);

  // Reject parameters that do not fit the counters.
  generate
    if (HP_DIED < 1 || HP_DIED > 32767 || HP_GOLD < 1 || HP_GOLD > 32767 ||
        HP_DIMOND < 1 || HP_DIMOND > 32767 || HP_SHOT < 1 || HP_SHOT > 32767) begin : g_bad_hp
      $error("buzzer_arbiter: half-period parameter outside 1..32767");
    end
    if (DUR_DIED < 1 || DUR_DIED > 63 || DUR_GOLD < 1 || DUR_GOLD > 63 ||
        DUR_DIMOND < 1 || DUR_DIMOND > 63 || DUR_SHOT < 1 || DUR_SHOT > 63) begin : g_bad_dur
      $error("buzzer_arbiter: duration parameter outside 1..63");
    end
    if (GAP_FRAMES < 1 || GAP_FRAMES > 3) begin : g_bad_gap
      $error("buzzer_arbiter: GAP_FRAMES outside 1..3");
    end
  endgenerate

  function automatic logic [TONE_W-1:0] hp_of(input logic [1:0] src);
    logic [TONE_W-1:0] hp;
    case (src)
      SND_DIED:   hp = TONE_W'(HP_DIED);
      SND_GOLD:   hp = TONE_W'(HP_GOLD);
      SND_DIMOND: hp = TONE_W'(HP_DIMOND);
      SND_SHOT:   hp = TONE_W'(HP_SHOT);
      default:    hp = TONE_W'(HP_DIED);
    endcase
    return hp;
  endfunction

  function automatic logic [FRAME_W-1:0] dur_of(input logic [1:0] src);
    logic [FRAME_W-1:0] dur;
    case (src)
      SND_DIED:   dur = FRAME_W'(DUR_DIED);
      SND_GOLD:   dur = FRAME_W'(DUR_GOLD);
      SND_DIMOND: dur = FRAME_W'(DUR_DIMOND);
      SND_SHOT:   dur = FRAME_W'(DUR_SHOT);
      default:    dur = FRAME_W'(DUR_DIED);
    endcase
    return dur;
  endfunction

  snd_state_t         state_r, state_s;
  logic [3:0]         pending_r, pending_s;
  logic [1:0]         active_src_r, active_src_s;
  logic [FRAME_W-1:0] frame_cnt_r, frame_cnt_s;
  logic [GAP_W-1:0]   gap_cnt_r, gap_cnt_s;
  logic               busy_r;
  logic [3:0]         req_vec_s;
  logic [1:0]         pick_s;
  logic               grant_s;
  logic               retrig_s;
  logic [3:0]         grant_mask_s;
  logic [3:0]         retrig_mask_s;
  logic               tone_clear_s;
  logic               wave_s;

  assign req_vec_s = {req_shot, req_dimond, req_gold, req_died};
  assign pick_s    = lowest_set(pending_r);

  // Arbitration, request latching and frame/gap timing.
  always_comb begin
    state_s       = state_r;
    pending_s     = pending_r;
    active_src_s  = active_src_r;
    frame_cnt_s   = frame_cnt_r;
    gap_cnt_s     = gap_cnt_r;
    grant_s       = 1'b0;
    retrig_s      = 1'b0;
    grant_mask_s  = 4'b0000;
    retrig_mask_s = 4'b0000;
    tone_clear_s  = 1'b1;

    if (mute) begin
      state_s     = IDLE;
      pending_s   = 4'b0000;
      frame_cnt_s = {FRAME_W{1'b0}};
      gap_cnt_s   = {GAP_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: grant_s = (pending_r != 4'b0000);
        PLAY: begin
          // Only strictly higher priority (lower index) may preempt.
          grant_s  = (pending_r != 4'b0000) && (pick_s < active_src_r);
          retrig_s = req_vec_s[active_src_r];
        end
        GAP:     grant_s = 1'b0;
        default: grant_s = 1'b0;
      endcase

      grant_mask_s  = grant_s ? (4'b0001 << pick_s) : 4'b0000;
      retrig_mask_s = retrig_s ? (4'b0001 << active_src_r) : 4'b0000;
      // A grant clears its bit even if the same source requests again now.
      pending_s = (pending_r | (req_vec_s & ~retrig_mask_s)) & ~grant_mask_s;

      if (grant_s) begin
        // Fresh sound: frame count loaded, a coincident frame strobe is ignored.
        state_s      = PLAY;
        active_src_s = pick_s;
        frame_cnt_s  = dur_of(pick_s);
        gap_cnt_s    = {GAP_W{1'b0}};
        tone_clear_s = 1'b1;
      end else begin
        case (state_r)
          PLAY: begin
            tone_clear_s = 1'b0;
            if (retrig_s) begin
              // Retrigger extends the sound but keeps the tone phase.
              frame_cnt_s = dur_of(active_src_r);
            end else if (startOfFrame) begin
              if (frame_cnt_r == 6'd1) begin
                state_s      = GAP;
                frame_cnt_s  = {FRAME_W{1'b0}};
                gap_cnt_s    = GAP_W'(GAP_FRAMES);
                tone_clear_s = 1'b1;
              end else begin
                frame_cnt_s = frame_cnt_r - 6'd1;
              end
            end else begin
              frame_cnt_s = frame_cnt_r;
            end
          end
          GAP: begin
            if (startOfFrame) begin
              if (gap_cnt_r == 2'd1) begin
                state_s   = IDLE;
                gap_cnt_s = {GAP_W{1'b0}};
              end else begin
                gap_cnt_s = gap_cnt_r - 2'd1;
              end
            end else begin
              gap_cnt_s = gap_cnt_r;
            end
          end
          IDLE:    state_s = IDLE;
          default: state_s = IDLE;
        endcase
      end
    end
  end

  // State and bookkeeping registers; busy is registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      pending_r    <= 4'b0000;
      active_src_r <= 2'd0;
      frame_cnt_r  <= {FRAME_W{1'b0}};
      gap_cnt_r    <= {GAP_W{1'b0}};
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      pending_r    <= pending_s;
      active_src_r <= active_src_s;
      frame_cnt_r  <= frame_cnt_s;
      gap_cnt_r    <= gap_cnt_s;
      busy_r       <= (state_s != IDLE);
    end
  end

  tone_gen u_tone (
    .clk         (clk),
    .reset       (reset),
    .clear       (tone_clear_s),
    .half_period (hp_of(active_src_r)),
    .wave        (wave_s)
  );

  assign buzzer     = wave_s;
  assign busy       = busy_r;
  assign active_src = active_src_r;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Self-checking bench for buzzer_arbiter: directed scenarios plus random
// traffic, compared against a frame/time-level reference model.
module tb_buzzer_arbiter;

  localparam int HP_D = 5;
  localparam int HP_G = 7;
  localparam int HP_M = 3;
  localparam int HP_S = 100;
  localparam int GAPF = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       startOfFrame = 1'b0;
  logic       mute = 1'b0;
  logic       req_died = 1'b0, req_gold = 1'b0, req_dimond = 1'b0, req_shot = 1'b0;
  logic       buzzer, busy;
  logic [1:0] active_src;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int frame_ctr = 0;
  int frame_period = 1000;

  int hp_tab [4] = '{HP_D, HP_G, HP_M, HP_S};
  int dur_tab[4] = '{30, 8, 4, 3};

  // Reference model: 0 idle, 1 playing, 2 silent gap.
  int         m_state = 0, m_src = 0, m_frames = 0, m_gap = 0, m_elapsed = 0;
  logic [3:0] m_pend = 4'b0000;

  buzzer_arbiter #(
    .HP_DIED(HP_D), .HP_GOLD(HP_G), .HP_DIMOND(HP_M), .HP_SHOT(HP_S),
    .DUR_DIED(30), .DUR_GOLD(8), .DUR_DIMOND(4), .DUR_SHOT(3), .GAP_FRAMES(GAPF)
  ) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .mute(mute),
    .req_died(req_died), .req_gold(req_gold), .req_dimond(req_dimond), .req_shot(req_shot),
    .buzzer(buzzer), .busy(busy), .active_src(active_src)
  );

  always #5 clk = ~clk;

  // Advance the model by one clock edge using the inputs that edge sampled.
  task automatic model_step();
    logic [3:0] reqs;
    int lo, grant;
    bit retrig;
    if (reset) begin
      m_state = 0; m_pend = 4'b0000; m_src = 0; m_frames = 0; m_gap = 0; m_elapsed = 0;
    end else if (mute) begin
      m_state = 0; m_pend = 4'b0000; m_frames = 0; m_gap = 0;
    end else begin
      reqs = {req_shot, req_dimond, req_gold, req_died};
      lo = -1;
      for (int i = 3; i >= 0; i--) if (m_pend[i]) lo = i;
      grant = -1;
      if (m_state == 0 && lo >= 0) grant = lo;
      if (m_state == 1 && lo >= 0 && lo < m_src) grant = lo;
      retrig = (m_state == 1) && reqs[m_src];
      if (retrig) reqs[m_src] = 1'b0;
      m_pend = m_pend | reqs;
      if (grant >= 0) begin
        m_pend[grant] = 1'b0;
        m_state = 1; m_src = grant; m_frames = dur_tab[grant]; m_elapsed = 0;
      end else if (m_state == 1) begin
        m_elapsed++;
        if (retrig) m_frames = dur_tab[m_src];
        else if (startOfFrame) begin
          if (m_frames == 1) begin m_state = 2; m_gap = GAPF; end
          else m_frames--;
        end
      end else if (m_state == 2) begin
        if (startOfFrame) begin
          if (m_gap == 1) m_state = 0;
          else m_gap--;
        end
      end
    end
  endtask

  // Expected {buzzer, busy, active_src}; tone is a function of time since grant.
  function automatic logic [3:0] model_vec();
    logic b;
    b = (m_state == 1) ? (((m_elapsed / hp_tab[m_src]) % 2) == 1) : 1'b0;
    return {b, (m_state != 0), 2'(m_src)};
  endfunction

  // One clock: update model, clear request pulses, drive the frame strobe.
  task automatic cycle();
    @(negedge clk);
    model_step();
    cyc++;
    req_died = 1'b0; req_gold = 1'b0; req_dimond = 1'b0; req_shot = 1'b0;
    frame_ctr++;
    if (frame_ctr >= frame_period) begin
      frame_ctr = 0;
      startOfFrame = 1'b1;
    end else begin
      startOfFrame = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cycle();
    n_checks++;
    if ({buzzer, busy, active_src, dut.pending_r} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_values got=%b want=00000000", {buzzer, busy, active_src, dut.pending_r});
    end
    reset = 1'b0;
    repeat (3) begin
      cycle();
      n_checks++;
      if ({buzzer, busy, active_src} !== model_vec()) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d got=%b want=%b", cyc, {buzzer, busy, active_src}, model_vec());
      end
    end
  endtask

  task automatic test_shot_timing();
    int grant_cyc, last_chg, n_sof;
    logic last_buz, s, b;
    frame_period = 1000; frame_ctr = 0;
    cycle();
    req_shot = 1'b1;
    cycle();
    n_checks++;
    if (busy !== 1'b0 || dut.pending_r !== 4'b1000) begin
      n_fail++;
      $display("FAIL shot_pending got busy=%b pend=%b want busy=0 pend=1000", busy, dut.pending_r);
    end
    cycle();
    n_checks++;
    if (busy !== 1'b1 || active_src !== 2'd3) begin
      n_fail++;
      $display("FAIL shot_busy got busy=%b src=%0d want busy=1 src=3", busy, active_src);
    end
    grant_cyc = cyc; last_chg = cyc; last_buz = 1'b0; n_sof = 0;
    for (int k = 0; k < 8000; k++) begin
      s = startOfFrame; b = busy;
      cycle();
      if (s && b) n_sof++;
      n_checks++;
      if ({buzzer, busy, active_src} !== model_vec()) begin
        n_fail++;
        $display("FAIL shot_cycle cyc=%0d got=%b want=%b", cyc, {buzzer, busy, active_src}, model_vec());
      end
      if (buzzer !== last_buz) begin
        if (m_state == 1) begin
          n_checks++;
          if (cyc - last_chg != HP_S) begin
            n_fail++;
            $display("FAIL shot_toggle_period got=%0d want=%0d", cyc - last_chg, HP_S);
          end
        end
        last_buz = buzzer; last_chg = cyc;
      end
      if (busy === 1'b0) break;
    end
    n_checks++;
    if (busy !== 1'b0 || n_sof != 5) begin
      n_fail++;
      $display("FAIL shot_length got busy=%b frames=%0d want busy=0 frames=5", busy, n_sof);
    end
    if (grant_cyc < 0) $display("unreachable");
  endtask

  task automatic test_same_cycle();
    int q[$];
    logic prev_busy;
    frame_period = 20;
    prev_busy = busy;
    req_gold = 1'b1; req_dimond = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      cycle();
      n_checks++;
      if ({buzzer, busy, active_src} !== model_vec()) begin
        n_fail++;
        $display("FAIL pair_cycle cyc=%0d got=%b want=%b", cyc, {buzzer, busy, active_src}, model_vec());
      end
      if (busy === 1'b1 && prev_busy === 1'b0) q.push_back(int'(active_src));
      prev_busy = busy;
      if (q.size() == 2 && busy === 1'b0) break;
    end
    n_checks++;
    if (q.size() != 2 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL pair_order got grants=%0d busy=%b want grants=2 busy=0", q.size(), busy);
    end else if (q[0] != 1 || q[1] != 2) begin
      n_fail++;
      $display("FAIL pair_order got %0d,%0d want 1,2", q[0], q[1]);
    end
  endtask

  task automatic test_preempt();
    int replays;
    logic prev_busy;
    req_shot = 1'b1;
    repeat (34) begin
      cycle();
      n_checks++;
      if ({buzzer, busy, active_src} !== model_vec()) begin
        n_fail++;
        $display("FAIL preempt_pre cyc=%0d got=%b want=%b", cyc, {buzzer, busy, active_src}, model_vec());
      end
    end
    req_died = 1'b1;
    cycle();
    cycle();
    n_checks++;
    if (active_src !== 2'd0 || busy !== 1'b1 || dut.u_tone.cnt_r !== 15'd0 || buzzer !== 1'b0) begin
      n_fail++;
      $display("FAIL preempt_grant got src=%0d busy=%b cnt=%0d buz=%b want src=0 busy=1 cnt=0 buz=0",
               active_src, busy, dut.u_tone.cnt_r, buzzer);
    end
    replays = 0; prev_busy = busy;
    repeat (900) begin
      cycle();
      n_checks++;
      if ({buzzer, busy, active_src} !== model_vec()) begin
        n_fail++;
        $display("FAIL preempt_cycle cyc=%0d got=%b want=%b", cyc, {buzzer, busy, active_src}, model_vec());
      end
      if (busy === 1'b1 && prev_busy === 1'b0) replays++;
      prev_busy = busy;
    end
    n_checks++;
    if (replays != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL preempt_no_replay got replays=%0d busy=%b want 0 and 0", replays, busy);
    end
  endtask

  task automatic test_retrigger();
    bit found;
    req_gold = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 400; k++) begin
      cycle();
      n_checks++;
      if ({buzzer, busy, active_src} !== model_vec()) begin
        n_fail++;
        $display("FAIL retrig_pre cyc=%0d got=%b want=%b", cyc, {buzzer, busy, active_src}, model_vec());
      end
      if (m_state == 1 && m_frames == 2 && startOfFrame == 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    req_gold = 1'b1;
    cycle();
    n_checks++;
    if (!found || dut.frame_cnt_r !== 6'd8 || dut.pending_r[1] !== 1'b0 ||
        {buzzer, busy, active_src} !== model_vec()) begin
      n_fail++;
      $display("FAIL retrig_reload got found=%0d frames=%0d pend1=%b out=%b want 1, 8, 0, %b",
               found, dut.frame_cnt_r, dut.pending_r[1], {buzzer, busy, active_src}, model_vec());
    end
    for (int k = 0; k < 600; k++) begin
      cycle();
      n_checks++;
      if ({buzzer, busy, active_src} !== model_vec()) begin
        n_fail++;
        $display("FAIL retrig_cycle cyc=%0d got=%b want=%b", cyc, {buzzer, busy, active_src}, model_vec());
      end
      if (busy === 1'b0) break;
    end
  endtask

  task automatic test_mute();
    req_gold = 1'b1;
    repeat (12) cycle();
    req_shot = 1'b1;
    cycle();
    n_checks++;
    if (dut.pending_r !== 4'b1000 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mute_setup got pend=%b busy=%b want 1000 and 1", dut.pending_r, busy);
    end
    mute = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      n_checks++;
      if (busy !== 1'b0 || buzzer !== 1'b0 || dut.pending_r !== 4'b0000) begin
        n_fail++;
        $display("FAIL mute_flush k=%0d got busy=%b buz=%b pend=%b want 0 0 0000", k, busy, buzzer, dut.pending_r);
      end
      if (k < 4) begin
        req_died = 1'b1; req_gold = 1'b1; req_dimond = 1'b1; req_shot = 1'b1;
      end
    end
    mute = 1'b0;
    repeat (50) begin
      cycle();
      n_checks++;
      if (busy !== 1'b0 || buzzer !== 1'b0 || {buzzer, busy, active_src} !== model_vec()) begin
        n_fail++;
        $display("FAIL mute_after cyc=%0d got=%b want=%b", cyc, {buzzer, busy, active_src}, model_vec());
      end
    end
  endtask

  task automatic test_random();
    int mute_left;
    mute_left = 0;
    frame_period = 20;
    for (int k = 0; k < 8000; k++) begin
      cycle();
      n_checks++;
      if ({buzzer, busy, active_src} !== model_vec()) begin
        n_fail++;
        $display("FAIL random cyc=%0d got=%b want=%b", cyc, {buzzer, busy, active_src}, model_vec());
      end
      req_died   = ($urandom_range(0, 59) == 0);
      req_gold   = ($urandom_range(0, 39) == 0);
      req_dimond = ($urandom_range(0, 39) == 0);
      req_shot   = ($urandom_range(0, 29) == 0);
      if (mute_left > 0) begin
        mute_left--;
        mute = (mute_left > 0);
      end else if ($urandom_range(0, 499) == 0) begin
        mute = 1'b1;
        mute_left = $urandom_range(1, 6);
      end
    end
    mute = 1'b0;
  endtask

  task automatic test_async_reset();
    bit found;
    mute = 1'b1;
    cycle();
    mute = 1'b0;
    cycle();
    req_gold = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 300; k++) begin
      cycle();
      n_checks++;
      if ({buzzer, busy, active_src} !== model_vec()) begin
        n_fail++;
        $display("FAIL areset_pre cyc=%0d got=%b want=%b", cyc, {buzzer, busy, active_src}, model_vec());
      end
      if (buzzer === 1'b1 && active_src === 2'd1) begin
        found = 1'b1;
        break;
      end
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (!found || {buzzer, busy, active_src, dut.pending_r} !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset got found=%0d out=%b want 1 and 00000000",
               found, {buzzer, busy, active_src, dut.pending_r});
    end
    cycle();
    reset = 1'b0;
    repeat (20) begin
      cycle();
      n_checks++;
      if ({buzzer, busy, active_src} !== model_vec()) begin
        n_fail++;
        $display("FAIL areset_post cyc=%0d got=%b want=%b", cyc, {buzzer, busy, active_src}, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_shot_timing();
    test_same_cycle();
    test_preempt();
    test_retrigger();
    test_mute();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
